// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Purpose : definitions shared by the byte-FIFO clients. These are the
//           packer state encoding, the default FIFO geometry and a helper
//           that sizes the saturating counters.
//
// Contents:
//   FIFO_DEPTH  - depth of the upstream byte FIFO (FIFO_8)
//   BYTE_W      - width of one FIFO entry
//   pk_state_t  - packer state: FILL (draining bytes) / HOLD (word presented)
//   cnt_width() - bits needed to count 0..n inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int BYTE_W     = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pk_state_t;

    // The counters must represent the full value n (not just n-1), so they
    // never have to wrap.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_word_packer_if
//
// Purpose : bundles the FIFO-side tap and the packed-word valid/ready port of
//           fifo_word_packer.
//
// Signals :
//   fifo_wen    producer write enable (tap into FIFO_8)
//   fifo_ren    FIFO read enable, driven by the packer
//   fifo_dout   FIFO read data, valid the cycle after a read
//   fifo_error  FIFO error flag
//   out_data    packed word, first byte read in the LSBs
//   out_valid   out_data valid
//   out_ready   downstream accepts out_data
//   occ         mirror of the FIFO occupancy
//   err_sticky  latched FIFO error
//
// Modports:
//   master - the packer
//   slave  - the environment (FIFO + producer tap + word consumer)
// -----------------------------------------------------------------------------
interface fifo_word_packer_if #(
    parameter int DATA_W = fifo_pkg::BYTE_W,
    parameter int BYTES  = 4,
    parameter int DEPTH  = fifo_pkg::FIFO_DEPTH
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                      fifo_wen;
    logic                      fifo_ren;
    logic [DATA_W-1:0]         fifo_dout;
    logic                      fifo_error;
    logic [DATA_W*BYTES-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [OCC_W-1:0]          occ;
    logic                      err_sticky;

    modport master (
        input  fifo_wen,
        input  fifo_dout,
        input  fifo_error,
        input  out_ready,
        output fifo_ren,
        output out_data,
        output out_valid,
        output occ,
        output err_sticky
    );

    modport slave (
        output fifo_wen,
        output fifo_dout,
        output fifo_error,
        output out_ready,
        input  fifo_ren,
        input  out_data,
        input  out_valid,
        input  occ,
        input  err_sticky
    );

endinterface

// File: rtl/occ_tracker.sv
// -----------------------------------------------------------------------------
// occ_tracker
//
// Purpose : saturating mirror of a FIFO's occupancy. It is meant for clients
//           of a FIFO that exposes no empty/full flags. The tracker follows
//           the FIFO's own rules: a read takes priority over a simultaneous
//           write, and a write into a full FIFO is dropped.
//
// Ports   :
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (occ -> 0)
//   wen   in   FIFO write enable
//   ren   in   FIFO read enable
//   occ   out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module occ_tracker
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic                       ren,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int               OCC_W   = cnt_width(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ONE_C   = OCC_W'(1);

    logic [OCC_W-1:0] occ_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg <= '0;
        end else if (ren) begin
            // The FIFO services only the read when both enables are high.
            // The zero guard keeps the mirror sane if a client ever reads
            // blind.
            if (occ_reg != '0) begin
                occ_reg <= occ_reg - ONE_C;
            end
        end else if (wen && (occ_reg < DEPTH_C)) begin
            occ_reg <= occ_reg + ONE_C;
        end
    end

    assign occ = occ_reg;

endmodule

// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Purpose : drains bytes from the flagless 8-deep byte FIFO (FIFO_8). It packs
//           BYTES of them (first byte in the LSBs) into a word and presents
//           that word on a valid/ready port. Reads are issued only when the
//           mirror occupancy says a byte is present. Reads are also withheld
//           in any cycle the producer writes, so the FIFO never sees a
//           colliding or underflowing read.
//
// Ports   :
//   clk   in      sole clock, rising edge
//   rst   in      synchronous active-high reset (the FIFO gets ~rst)
//   bus   master  fifo_word_packer_if: FIFO tap, packed-word port, occ,
//                 err_sticky
//
// Parameters: DATA_W (byte width), BYTES (bytes per word, >= 2),
//             DEPTH (FIFO depth for the occupancy mirror)
//
// Build option: define PACKER_ERR_CHECK_EN to latch fifo_error into
//               err_sticky (cleared only by rst). Without it fifo_error is
//               ignored and err_sticky is 0.
//
// Timing: the first read in cycle c (bytes present, no writes) gives
//         out_valid in cycle c+BYTES+1. out_data/out_valid hold while
//         out_ready is low.
// -----------------------------------------------------------------------------
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int BYTES  = 4,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    fifo_word_packer_if.master bus
);

    localparam int               CNT_W   = cnt_width(BYTES);
    localparam int               OCC_W   = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] BYTES_C = CNT_W'(BYTES);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    pk_state_t        state_reg;
    logic [CNT_W-1:0] issued_reg;     // reads issued for the current word
    logic [CNT_W-1:0] captured_reg;   // bytes already written into lanes
    logic             rd_pend_reg;    // read issued last cycle -> dout valid now
    logic             out_valid_reg;
    logic [OCC_W-1:0] occ;
    logic             ren;
    logic             accept;

    // -------------------------------------------------------------------------
    // Read enable. It is combinational on registered state and the write
    // tap, so a read never lands in a write cycle. During rst it is forced
    // low so the FIFO and the mirror come out of reset together.
    // -------------------------------------------------------------------------
    assign ren = !rst
              && (state_reg == FILL)
              && (issued_reg < BYTES_C)
              && (occ != '0)
              && !bus.fifo_wen;

    assign accept = (state_reg == HOLD) && out_valid_reg && bus.out_ready;

    occ_tracker #(
        .DEPTH (DEPTH)
    ) u_occ_tracker (
        .clk (clk),
        .rst (rst),
        .wen (bus.fifo_wen),
        .ren (ren),
        .occ (occ)
    );

    // -------------------------------------------------------------------------
    // Control FSM. issued runs ahead of captured by the one-cycle FIFO read
    // latency. The word is complete on the edge that captures lane BYTES-1.
    // By then issued has already reached BYTES, so no stray read is left in
    // flight when entering HOLD.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FILL;
            issued_reg    <= '0;
            captured_reg  <= '0;
            rd_pend_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            rd_pend_reg <= ren;
            unique case (state_reg)
                FILL: begin
                    if (ren) begin
                        issued_reg <= issued_reg + ONE_C;
                    end
                    if (rd_pend_reg) begin
                        captured_reg <= captured_reg + ONE_C;
                        if (captured_reg == LAST_C) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        state_reg     <= FILL;
                        out_valid_reg <= 1'b0;
                        issued_reg    <= '0;
                        captured_reg  <= '0;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Byte lanes. Lane gi loads fifo_dout when the pending read is the
    // gi-th byte of the word. All lanes clear on acceptance, so a new word
    // never shows stale bytes.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [DATA_W-1:0] lane_reg;

        always_ff @(posedge clk) begin
            if (rst || accept) begin
                lane_reg <= '0;
            end else if (rd_pend_reg && (captured_reg == CNT_W'(gi))) begin
                lane_reg <= bus.fifo_dout;
            end
        end

        assign bus.out_data[gi*DATA_W +: DATA_W] = lane_reg;
    end

    // -------------------------------------------------------------------------
    // FIFO error capture
    // -------------------------------------------------------------------------
`ifdef PACKER_ERR_CHECK_EN
    logic err_sticky_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_reg <= 1'b0;
        end else if (bus.fifo_error) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign bus.err_sticky = err_sticky_reg;
`else
    logic unused_fifo_error;

    assign unused_fifo_error = bus.fifo_error;
    assign bus.err_sticky    = 1'b0;
`endif

    assign bus.fifo_ren  = ren;
    assign bus.out_valid = out_valid_reg;
    assign bus.occ       = occ;

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// The bench holds a behavioural FIFO_8 (a queue) that feeds the packer. Every
// byte the FIFO accepts is also pushed into a reference list. Each group of
// BYTES accepted bytes becomes one expected word, first byte in the LSBs.
// Words leaving the packer are compared against that list in order.
// Per-cycle checks cover the read/write exclusion, the occupancy mirror
// against the queue size, err_sticky, and output stability under
// backpressure. The directed scenarios come first, followed by a randomized
// phase.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

    localparam int DATA_W = 8;
    localparam int BYTES  = 4;
    localparam int DEPTH  = 8;
    localparam int WORD_W = DATA_W * BYTES;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = '0;

    always #5 clk = ~clk;

    fifo_word_packer_if #(.DATA_W(DATA_W), .BYTES(BYTES), .DEPTH(DEPTH)) bus ();

    fifo_word_packer #(
        .DATA_W (DATA_W),
        .BYTES  (BYTES),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [WORD_W-1:0] pack(input logic [DATA_W-1:0] b[$]);
        logic [WORD_W-1:0] w = '0;
        for (int i = 0; i < b.size(); i++) w[i*DATA_W +: DATA_W] = b[i];
        return w;
    endfunction

    // ---------------- FIFO_8 model + reference word list ----------------
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] acc_q[$];
    logic [WORD_W-1:0] exp_words[$];
    logic              sticky_exp = 1'b0;
    int                err_seen   = 0;

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            acc_q.delete();
            exp_words.delete();
            bus.fifo_dout  <= '0;
            bus.fifo_error <= 1'b0;
            sticky_exp     <= 1'b0;
        end else begin
`ifdef PACKER_ERR_CHECK_EN
            if (bus.fifo_error) sticky_exp <= 1'b1;
`endif
            if (bus.fifo_error) err_seen++;
            bus.fifo_error <= 1'b0;
            if (bus.fifo_ren) begin
                if (fifo_q.size() == 0) bus.fifo_error <= 1'b1;
                else bus.fifo_dout <= fifo_q.pop_front();
            end else if (bus.fifo_wen) begin
                if (fifo_q.size() >= DEPTH) begin
                    bus.fifo_error <= 1'b1;
                end else begin
                    fifo_q.push_back(din);
                    acc_q.push_back(din);
                    if (acc_q.size() == BYTES) begin
                        exp_words.push_back(pack(acc_q));
                        acc_q.delete();
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic              prev_hold = 1'b0;
    logic [WORD_W-1:0] prev_data = '0;
    int                valid_cycles = 0;
    int                words_out    = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            check_eq("ren_vs_wen", bus.fifo_ren && bus.fifo_wen, 0);
            check_eq("occ_mirror", bus.occ, fifo_q.size());
            check_eq("err_sticky", bus.err_sticky, sticky_exp);
            if (prev_hold) begin
                check_eq("hold_valid", bus.out_valid, 1);
                check_eq("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && bus.out_ready) begin
                check_eq("word_expected", exp_words.size() != 0, 1);
                if (exp_words.size() != 0) begin
                    $display("word out 0x%08h", bus.out_data);
                    check_eq("word", bus.out_data, exp_words.pop_front());
                end
                words_out++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic wen, input logic [DATA_W-1:0] d);
        @(posedge clk);
        #1;
        bus.fifo_wen = wen;
        din          = d;
    endtask

    task automatic write_bytes(input logic [DATA_W-1:0] b[$]);
        for (int i = 0; i < b.size(); i++) drive(1'b1, b[i]);
        drive(1'b0, '0);
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n = 0;
        while (!bus.out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, bus.out_valid, 1);
    endtask

    task automatic wait_ren(input int max, input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.fifo_ren && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, bus.fifo_ren, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    // ---------------- test sequence ----------------
    logic [DATA_W-1:0] bq[$];
    int                lat;
    int                w0;

    initial begin
        bus.fifo_wen  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_data", bus.out_data, 0);
        check_eq("rst_occ", bus.occ, 0);
        check_eq("rst_err", bus.err_sticky, 0);
        check_eq("rst_ren", bus.fifo_ren, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_ren", bus.fifo_ren, 0);
        end

        // Single word with latency measurement
        bus.out_ready = 1'b1;
        valid_cycles  = 0;
        bq = '{8'd56, 8'd11, 8'd42, 8'd10};
        write_bytes(bq);
        wait_ren(20, "single_ren_timeout");
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("single_latency", lat, BYTES + 1);
        check_eq("single_word", bus.out_data, 32'h0A2A0B38);
        idle(10);
        check_eq("single_valid_cycles", valid_cycles, 1);
        check_eq("single_occ", bus.occ, 0);
        check_eq("single_no_error", err_seen, 0);
        $display("single word done");

        // Backpressure
        bus.out_ready = 1'b0;
        bq = '{8'd23, 8'd20, 8'd6, 8'd85, 8'd45, 8'd12, 8'd77, 8'd1};
        write_bytes(bq);
        wait_valid(40, "bp_valid_timeout");
        idle(5);
        @(negedge clk);
        check_eq("bp_hold_data", bus.out_data, 32'h55061417);
        check_eq("bp_hold_valid", bus.out_valid, 1);
        check_eq("bp_occ", bus.occ, 4);
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wait_valid(40, "bp_second_timeout");
        check_eq("bp_second_word", bus.out_data, 32'h014D0C2D);
        idle(5);
        $display("backpressure done");

        // Interleaved writes
        w0 = words_out;
        for (int i = 0; i < 16; i++) drive((i % 2) == 0, DATA_W'($urandom));
        idle(30);
        check_eq("interleave_words", words_out - w0, 2);
        check_eq("interleave_drained", exp_words.size(), 0);
        $display("interleave done");

        // Overflow: nine back-to-back writes, no reads possible
        bus.out_ready = 1'b0;
        bq.delete();
        for (int i = 0; i < 9; i++) bq.push_back(DATA_W'($urandom));
        for (int i = 0; i < 9; i++) drive(1'b1, bq[i]);
        drive(1'b0, '0);
        @(negedge clk);
        check_eq("ovf_occ", bus.occ, DEPTH);
        @(negedge clk);
`ifdef PACKER_ERR_CHECK_EN
        check_eq("ovf_sticky", bus.err_sticky, 1);
`else
        check_eq("ovf_sticky", bus.err_sticky, 0);
`endif
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        idle(40);
        check_eq("ovf_drained", exp_words.size(), 0);
        $display("overflow done");

        // Mid-word reset after two bytes captured
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_bytes(bq);
        wait_ren(20, "mid_ren_timeout");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", bus.out_valid, 0);
        check_eq("mid_rst_occ", bus.occ, 0);
        check_eq("mid_rst_ren", bus.fifo_ren, 0);
        check_eq("mid_rst_err", bus.err_sticky, 0);
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        write_bytes(bq);
        wait_valid(40, "mid_valid_timeout");
        check_eq("mid_fresh_word", bus.out_data, 32'hEFBEADDE);
        idle(5);
        $display("mid-word reset done");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55, DATA_W'($urandom));
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        idle(60);
        check_eq("rand_drained", exp_words.size(), 0);
        check_eq("rand_occ", bus.occ, 0);
        $display("random phase done, %0d words out", words_out);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
